branch_history_table: RTL and testbench

- Fully associative branch target buffer with per-entry 2-bit saturating counters. It supports dynamic branch prediction in the 5-stage MIPS pipeline.
- IF stage queries with pc+4 and gets a predicted-taken flag and a target address, both combinational.
- EXE stage writes back the resolved outcome of each branch/jump, keyed by the same pc+4 value.

---
 rtl/bht_pkg.sv | 21 ++
 rtl/sat_counter2.sv | 22 ++
 rtl/branch_history_table.sv | 115 +++++++++++
 tb/tb_branch_history_table.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// Shared definitions for the branch history table: default sizes,
// 2-bit counter encodings and the table entry layout.
package bht_pkg;

    localparam int unsigned ENTRIES_DEF = 8;
    localparam int unsigned ADDR_W_DEF  = 12;

    localparam logic [1:0] CNT_SNT = 2'd0;
    localparam logic [1:0] CNT_WNT = 2'd1;
    localparam logic [1:0] CNT_WT  = 2'd2;
    localparam logic [1:0] CNT_ST  = 2'd3;

    // Entry layout at the default address width
    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] tag;
        logic [ADDR_W_DEF-1:0] target;
        logic [1:0]            cnt;
    } bht_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Combinational 2-bit saturating counter step: increment on inc=1,
// decrement otherwise, clamping at strongly taken / strongly not-taken.
module sat_counter2
    import bht_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       inc,
    output logic [1:0] cnt_nxt_c
);

    always_comb begin
        cnt_nxt_c = cnt;
        if (inc) begin
            if (cnt != CNT_ST) begin
                cnt_nxt_c = cnt + 2'd1;
            end
        end else if (cnt != CNT_SNT) begin
            cnt_nxt_c = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_history_table.sv
// Fully associative branch target buffer with 2-bit saturating counters.
// Combinational lookup from IF, edge-triggered update from EXE.
module branch_history_table
    import bht_pkg::*;
#(
    parameter int unsigned ENTRIES = ENTRIES_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] insert_ins_addr,
    input  logic [ADDR_W-1:0] insert_ins_next_addr,
    input  logic              is_branch,
    input  logic              is_suc,
    input  logic [ADDR_W-1:0] query_ins_addr,
    output logic [ADDR_W-1:0] predict_addr,
    output logic              predict_jump
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] tag;
        logic [ADDR_W-1:0] target;
        logic [1:0]        cnt;
    } entry_t;

    entry_t           tbl [ENTRIES];
    logic [IDX_W-1:0] vptr;

    logic             q_hit;
    logic [IDX_W-1:0] q_idx;
    logic             i_hit;
    logic [IDX_W-1:0] i_idx;
    logic             inv_found;
    logic [IDX_W-1:0] inv_idx;
    logic [IDX_W-1:0] victim_idx;
    logic [1:0]       cnt_nxt;

    // Query match; tags are unique so at most one entry can hit
    always_comb begin
        q_hit = 1'b0;
        q_idx = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (tbl[i].valid && (tbl[i].tag == query_ins_addr)) begin
                q_hit = 1'b1;
                q_idx = IDX_W'(i);
            end
        end
    end

    // Update-key match
    always_comb begin
        i_hit = 1'b0;
        i_idx = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (tbl[i].valid && (tbl[i].tag == insert_ins_addr)) begin
                i_hit = 1'b1;
                i_idx = IDX_W'(i);
            end
        end
    end

    // Lowest-index free entry: scanning downward leaves the lowest one last
    always_comb begin
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!tbl[i].valid) begin
                inv_found = 1'b1;
                inv_idx   = IDX_W'(i);
            end
        end
    end

    assign victim_idx = inv_found ? inv_idx : vptr;

    sat_counter2 u_sat_counter2 (
        .cnt       (tbl[i_idx].cnt),
        .inc       (is_suc),
        .cnt_nxt_c (cnt_nxt)
    );

    assign predict_jump = q_hit && (tbl[q_idx].cnt >= CNT_WT);
    assign predict_addr = predict_jump ? tbl[q_idx].target : query_ins_addr;

    // Table and round-robin pointer; the pointer only moves when a live entry is evicted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl[i] <= '0;
            end
            vptr <= '0;
        end else if (is_branch) begin
            if (i_hit) begin
                tbl[i_idx].cnt <= cnt_nxt;
                if (is_suc) begin
                    tbl[i_idx].target <= insert_ins_next_addr;
                end
            end else if (is_suc) begin
                tbl[victim_idx] <= entry_t'{
                    valid:  1'b1,
                    tag:    insert_ins_addr,
                    target: insert_ins_next_addr,
                    cnt:    CNT_WT
                };
                if (!inv_found) begin
                    vptr <= vptr + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table: directed scenarios with
// fixed expectations, then random traffic against a behavioural table model.
module tb_branch_history_table;

    localparam int N  = 8;
    localparam int AW = 12;

    logic          clk;
    logic          rst;
    logic [AW-1:0] insert_ins_addr;
    logic [AW-1:0] insert_ins_next_addr;
    logic          is_branch;
    logic          is_suc;
    logic [AW-1:0] query_ins_addr;
    logic [AW-1:0] predict_addr;
    logic          predict_jump;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    bit            m_valid [N];
    logic [AW-1:0] m_tag   [N];
    logic [AW-1:0] m_tgt   [N];
    int            m_cnt   [N];
    int            m_vptr;

    branch_history_table #(.ENTRIES(N), .ADDR_W(AW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .insert_ins_addr      (insert_ins_addr),
        .insert_ins_next_addr (insert_ins_next_addr),
        .is_branch            (is_branch),
        .is_suc               (is_suc),
        .query_ins_addr       (query_ins_addr),
        .predict_addr         (predict_addr),
        .predict_jump         (predict_jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_cnt[i]   = 0;
        end
        m_vptr = 0;
    endfunction

    function automatic void model_predict(input logic [AW-1:0] q, output logic ej, output logic [AW-1:0] ea);
        ej = 1'b0;
        ea = q;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_tag[i] == q && m_cnt[i] >= 2) begin
                ej = 1'b1;
                ea = m_tgt[i];
            end
        end
    endfunction

    function automatic void model_update(input logic [AW-1:0] ia, input logic [AW-1:0] na, input bit suc);
        int h = -1;
        int v = -1;
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_tag[i] == ia) h = i;
        if (h >= 0) begin
            if (suc) begin
                m_cnt[h] = (m_cnt[h] + 1 > 3) ? 3 : m_cnt[h] + 1;
                m_tgt[h] = na;
            end else begin
                m_cnt[h] = (m_cnt[h] - 1 < 0) ? 0 : m_cnt[h] - 1;
            end
        end else if (suc) begin
            for (int i = N - 1; i >= 0; i--)
                if (!m_valid[i]) v = i;
            if (v < 0) begin
                v      = m_vptr;
                m_vptr = (m_vptr + 1) % N;
            end
            m_valid[v] = 1'b1;
            m_tag[v]   = ia;
            m_tgt[v]   = na;
            m_cnt[v]   = 2;
        end
    endfunction

    // Compare current outputs with the model for the current query
    task automatic check_model(input string tag);
        logic          ej;
        logic [AW-1:0] ea;
        model_predict(query_ins_addr, ej, ea);
        check({tag, "_jump"}, AW'(predict_jump), AW'(ej));
        check({tag, "_addr"}, predict_addr, ea);
    endtask

    // Combinational probe with no update, against fixed expectations
    task automatic probe(input string tag, input logic [AW-1:0] q, input logic ej, input logic [AW-1:0] ea);
        is_branch      = 1'b0;
        query_ins_addr = q;
        #1;
        check({tag, "_jump"}, AW'(predict_jump), AW'(ej));
        check({tag, "_addr"}, predict_addr, ea);
    endtask

    // One update cycle; the query is checked against the pre-edge model
    task automatic drive(input bit ib, input bit suc, input logic [AW-1:0] ia,
                         input logic [AW-1:0] na, input logic [AW-1:0] q);
        @(negedge clk);
        is_branch            = ib;
        is_suc               = suc;
        insert_ins_addr      = ia;
        insert_ins_next_addr = na;
        query_ins_addr       = q;
        #1;
        check_model("pre_edge");
        @(posedge clk);
        if (ib) model_update(ia, na, suc);
        #1;
        is_branch = 1'b0;
    endtask

    initial begin
        rst                  = 1'b1;
        is_branch            = 1'b0;
        is_suc               = 1'b0;
        insert_ins_addr      = '0;
        insert_ins_next_addr = '0;
        query_ins_addr       = '0;
        model_reset();
        #2;
        probe("reset_state", 12'h010, 1'b0, 12'h010);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // First taken insert
        drive(1, 1, 12'h014, 12'h040, 12'h014);
        probe("first_hit", 12'h014, 1'b1, 12'h040);
        probe("first_miss", 12'h018, 1'b0, 12'h018);

        // Hysteresis
        drive(1, 1, 12'h014, 12'h040, 12'h014);
        drive(1, 0, 12'h014, 12'h000, 12'h014);
        probe("hyst_cnt2", 12'h014, 1'b1, 12'h040);
        drive(1, 0, 12'h014, 12'h000, 12'h014);
        probe("hyst_cnt1", 12'h014, 1'b0, 12'h014);
        repeat (3) drive(1, 0, 12'h014, 12'h000, 12'h014);
        drive(1, 1, 12'h014, 12'h040, 12'h014);
        probe("hyst_floor", 12'h014, 1'b0, 12'h014);
        drive(1, 1, 12'h014, 12'h040, 12'h014);
        probe("hyst_back", 12'h014, 1'b1, 12'h040);

        // Miss not-taken allocates nothing
        drive(1, 0, 12'h020, 12'h060, 12'h020);
        probe("miss_nt", 12'h020, 1'b0, 12'h020);
        drive(1, 1, 12'h020, 12'h060, 12'h020);
        probe("alloc_wt", 12'h020, 1'b1, 12'h060);

        // Target change, then gated update
        drive(1, 1, 12'h014, 12'h080, 12'h014);
        probe("tgt_change", 12'h014, 1'b1, 12'h080);
        drive(0, 1, 12'h014, 12'h0C0, 12'h014);
        probe("gated", 12'h014, 1'b1, 12'h080);

        // Asynchronous reset of a populated table, checked before any clock edge
        @(negedge clk);
        rst = 1'b1;
        probe("arst_014", 12'h014, 1'b0, 12'h014);
        probe("arst_020", 12'h020, 1'b0, 12'h020);
        probe("arst_010", 12'h010, 1'b0, 12'h010);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        probe("arst_held", 12'h014, 1'b0, 12'h014);
        @(negedge clk);
        rst = 1'b0;

        // Replacement: N+1 distinct keys evict entry 0
        for (int k = 1; k <= N + 1; k++)
            drive(1, 1, AW'(4 * k), AW'(12'h100 + 4 * k), AW'(4 * k));
        probe("evict_first", 12'h004, 1'b0, 12'h004);
        for (int k = 2; k <= N + 1; k++)
            probe("evict_keep", AW'(4 * k), 1'b1, AW'(12'h100 + 4 * k));
        drive(1, 1, 12'h028, 12'h128, 12'h028);
        probe("evict_second", 12'h008, 1'b0, 12'h008);
        probe("new_hit", 12'h028, 1'b1, 12'h128);
        probe("keep_00c", 12'h00C, 1'b1, 12'h10C);

        // Same-edge query of the key being inserted misses in that cycle
        @(negedge clk);
        is_branch            = 1'b1;
        is_suc               = 1'b1;
        insert_ins_addr      = 12'h02C;
        insert_ins_next_addr = 12'h12C;
        query_ins_addr       = 12'h02C;
        #1;
        check("same_edge_jump", AW'(predict_jump), AW'(1'b0));
        check("same_edge_addr", predict_addr, 12'h02C);
        @(posedge clk);
        model_update(12'h02C, 12'h12C, 1'b1);
        #1;
        probe("after_edge", 12'h02C, 1'b1, 12'h12C);
        probe("evict_third", 12'h00C, 1'b0, 12'h00C);

        // Random traffic over a small key pool to exercise hits, saturation and eviction
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] ia;
            logic [AW-1:0] q;
            ia = AW'(4 * $urandom_range(1, 12));
            q  = ($urandom_range(0, 1) == 0) ? ia : AW'(4 * $urandom_range(1, 12));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ia, AW'($urandom), q);
        end
        for (int k = 1; k <= 12; k++) begin
            query_ins_addr = AW'(4 * k);
            #1;
            check_model("final_sweep");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
